sramlike_axi_bridge: RTL and testbench

//   Responder end of the sram-like req/addr_ok/data_ok interface driven by the I/D caches.

---
 rtl/sramlike_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_axi_bridge.sv
// Bridge from the cache-side sram-like req/addr_ok/data_ok handshake to a single-beat AXI master.
// One transaction in flight at a time; all AXI-facing valid/ready strobes are registered.
module sramlike_axi_bridge #(
  parameter bit WSTRB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // sram-like responder side
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  // AXI master side
  output logic [31:0] axi_addr,
  output logic [2:0]  axi_size,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAwW,
    StB,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        data_ok_q, data_ok_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_fire, w_fire;
  logic [3:0]  wstrb;

  assign addr_ok = req & (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    data_ok_d = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fire   = awvalid_q & axi_awready;
    w_fire    = wvalid_q & axi_wready;

    case (state_q)
      StIdle: begin
        if (req) begin
          size_d    = size;
          addr_d    = addr;
          wdata_d   = wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StAwW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StAr;
          end
        end
      end
      StAr: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StR;
        end
      end
      StR: begin
        if (axi_rvalid) begin
          rdata_d   = axi_rdata;
          rready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = StDone;
        end
      end
      StAwW: begin
        // AW and W complete independently; each valid drops after its own handshake.
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire) wvalid_d = 1'b0;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = StB;
        end
      end
      StB: begin
        if (axi_bvalid) begin
          bready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_comb begin
    wstrb = 4'hf;
    if (WSTRB_EN) begin
      case (size_q)
        2'd0:    wstrb = 4'b0001 << addr_q[1:0];
        2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: wstrb = 4'b1111;
      endcase
    end
  end

  // Reset abandons any in-flight beat; the AXI slave is expected to be reset alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      data_ok_q <= data_ok_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign rdata       = rdata_q;
  assign data_ok     = data_ok_q;
  assign axi_addr    = addr_q;
  assign axi_size    = {1'b0, size_q};
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed bench for sramlike_axi_bridge: reads, writes, handshake skew, back-to-back, mid-flight reset.
module tb_sramlike_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic [31:0] axi_addr;
  logic [2:0]  axi_size;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  sramlike_axi_bridge #(.WSTRB_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .wr          (wr),
    .size        (size),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .addr_ok     (addr_ok),
    .data_ok     (data_ok),
    .axi_addr    (axi_addr),
    .axi_size    (axi_size),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready)
  );

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let freshly driven inputs propagate before sampling.
  task automatic look();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed snapshot of every valid/ready strobe plus data_ok.
  function automatic logic [31:0] strobes();
    return {26'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, data_ok};
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    cyc(); cyc();
    look();
    chk("reset_strobes", strobes(), 32'h0);
    chk("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_axi_addr", axi_addr, 32'h0);
    chk("reset_axi_wdata", axi_wdata, 32'h0);
    cyc(); rst = 1'b0;

    // 1) zero-wait read
    cyc();
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h2408_0001;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'hBFC0_0000;
    look();
    chk("rd0_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; addr = 32'h0; look();
    chk("rd0_t1_strobes", strobes(), 32'b100000);
    chk("rd0_t1_axi_addr", axi_addr, 32'hBFC0_0000);
    chk("rd0_t1_axi_size", {29'd0, axi_size}, 32'd2);
    cyc(); look();
    chk("rd0_t2_strobes", strobes(), 32'b010000);
    cyc(); look();
    chk("rd0_t3_strobes", strobes(), 32'b000001);
    chk("rd0_t3_rdata", rdata, 32'h2408_0001);
    cyc(); look();
    chk("rd0_t4_strobes", strobes(), 32'b000000);

    // 2) read with arready late by 3 cycles, rvalid 2 cycles after R entry; req held high
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    cyc();
    req = 1'b1; wr = 1'b0; addr = 32'h1000_0004; look();
    chk("rd1_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) axi_arready = 1'b1;
      look();
      chk("rd1_ar_hold_strobes", strobes(), 32'b100000);
      chk("rd1_ar_busy_addr_ok", {31'd0, addr_ok}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      axi_arready = 1'b0;
      if (i == 2) begin axi_rvalid = 1'b1; axi_rdata = 32'h1234_5678; end
      look();
      chk("rd1_r_wait_strobes", strobes(), 32'b010000);
      chk("rd1_r_busy_addr_ok", {31'd0, addr_ok}, 32'd0);
    end
    cyc(); axi_rvalid = 1'b0; look();
    chk("rd1_done_strobes", strobes(), 32'b000001);
    chk("rd1_done_rdata", rdata, 32'h1234_5678);
    chk("rd1_done_addr_ok", {31'd0, addr_ok}, 32'd0);
    req = 1'b0;
    cyc(); look();
    chk("rd1_after_strobes", strobes(), 32'b000000);

    // 3) byte write to addr[1:0]=3
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0;
    cyc();
    req = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h0000_0003; wdata = 32'hAABB_CCDD; look();
    chk("wr0_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; wdata = 32'h0; look();
    chk("wr0_t1_strobes", strobes(), 32'b001100);
    chk("wr0_t1_wstrb", {28'd0, axi_wstrb}, 32'b1000);
    chk("wr0_t1_wdata", axi_wdata, 32'hAABB_CCDD);
    chk("wr0_t1_size", {29'd0, axi_size}, 32'd0);
    cyc(); look();
    chk("wr0_t2_strobes", strobes(), 32'b000010);
    cyc(); axi_bvalid = 1'b1; look();
    chk("wr0_t3_strobes", strobes(), 32'b000010);
    cyc(); axi_bvalid = 1'b0; look();
    chk("wr0_t4_strobes", strobes(), 32'b000001);
    chk("wr0_t4_rdata_kept", rdata, 32'h1234_5678);
    cyc(); look();
    chk("wr0_t5_strobes", strobes(), 32'b000000);

    // 4) halfword write, W handshakes two cycles before AW
    axi_awready = 1'b0; axi_wready = 1'b1;
    cyc();
    req = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h2000_0002; wdata = 32'h5566_7788; look();
    chk("wr1_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; look();
    chk("wr1_t1_strobes", strobes(), 32'b001100);
    chk("wr1_t1_wstrb", {28'd0, axi_wstrb}, 32'b1100);
    cyc(); axi_wready = 1'b0; look();
    chk("wr1_t2_strobes", strobes(), 32'b001000);
    cyc(); axi_awready = 1'b1; look();
    chk("wr1_t3_strobes", strobes(), 32'b001000);
    cyc(); axi_awready = 1'b0; axi_bvalid = 1'b1; look();
    chk("wr1_t4_strobes", strobes(), 32'b000010);
    cyc(); axi_bvalid = 1'b0; look();
    chk("wr1_t5_strobes", strobes(), 32'b000001);
    cyc(); look();
    chk("wr1_t6_strobes", strobes(), 32'b000000);

    // 5) back-to-back read then write with req held high
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'hCAFE_F00D;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    cyc();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h3000_0000; look();
    chk("b2b_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); wr = 1'b1; addr = 32'h3000_0010; wdata = 32'h1122_3344; look();
    chk("b2b_t1_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("b2b_t1_axi_addr", axi_addr, 32'h3000_0000);
    cyc(); look();
    chk("b2b_t2_addr_ok", {31'd0, addr_ok}, 32'd0);
    cyc(); axi_rdata = 32'hDEAD_BEEF; look();
    chk("b2b_t3_strobes", strobes(), 32'b000001);
    chk("b2b_t3_rdata", rdata, 32'hCAFE_F00D);
    chk("b2b_t3_addr_ok", {31'd0, addr_ok}, 32'd0);
    cyc(); look();
    chk("b2b_t4_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; look();
    chk("b2b_t5_strobes", strobes(), 32'b001100);
    chk("b2b_t5_axi_addr", axi_addr, 32'h3000_0010);
    chk("b2b_t5_wdata", axi_wdata, 32'h1122_3344);
    cyc(); look();
    chk("b2b_t6_strobes", strobes(), 32'b000010);
    cyc(); look();
    chk("b2b_t7_strobes", strobes(), 32'b000001);
    chk("b2b_t7_rdata_kept", rdata, 32'hCAFE_F00D);
    cyc(); look();
    chk("b2b_t8_strobes", strobes(), 32'b000000);

    // 6) reset asserted while in R, then immediate new read
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    axi_arready = 1'b1; axi_rvalid = 1'b0;
    cyc();
    req = 1'b1; wr = 1'b0; addr = 32'h4000_0000; look();
    chk("rst_t0_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; look();
    chk("rst_t1_strobes", strobes(), 32'b100000);
    cyc(); rst = 1'b1; look();
    chk("rst_t2_strobes", strobes(), 32'b010000);
    cyc(); look();
    chk("rst_t3_strobes", strobes(), 32'b000000);
    rst = 1'b0; req = 1'b1; addr = 32'h5000_0000; look();
    chk("rst_t3_addr_ok", {31'd0, addr_ok}, 32'd1);
    cyc(); req = 1'b0; look();
    chk("rst_t4_strobes", strobes(), 32'b100000);
    chk("rst_t4_axi_addr", axi_addr, 32'h5000_0000);
    cyc(); axi_rvalid = 1'b1; axi_rdata = 32'h5555_AAAA; look();
    chk("rst_t5_strobes", strobes(), 32'b010000);
    cyc(); axi_rvalid = 1'b0; look();
    chk("rst_t6_strobes", strobes(), 32'b000001);
    chk("rst_t6_rdata", rdata, 32'h5555_AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
